// File: rtl/pair_adder_if.sv
// Operand beat stream in, paired sum stream out; master drives operands and
// consumes sums, slave is the adder.
interface pair_adder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             data_in_valid;
    logic             data_in_ready;
    logic [WIDTH:0]   sum;
    logic             sum_valid;
    logic             sum_ready;

    modport master (
        output data_in, data_in_valid, sum_ready,
        input  data_in_ready, sum, sum_valid
    );

    modport slave (
        input  data_in, data_in_valid, sum_ready,
        output data_in_ready, sum, sum_valid
    );
endinterface

// File: rtl/pair_adder.sv
// Pairs serial operand beats (A then B) and registers their WIDTH+1-bit sum; PAIR_ADDER_SIGNED_EN selects sign extension.
// Latency: sum valid one cycle after the B beat is accepted; peak one result every 2 cycles.
// Backpressure: a held result blocks input (ready follows sum ready combinationally while a result is pending).
module pair_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk_i,
    input  logic          arst_ni,
    pair_adder_if.slave   bus
);

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH:0]   sum_q;
    logic             sum_valid_q;
    logic             in_hs;
    logic             out_hs;

    function automatic logic [WIDTH:0] ext(input logic [WIDTH-1:0] x);
`ifdef PAIR_ADDER_SIGNED_EN
        return {x[WIDTH-1], x};
`else
        return {1'b0, x};
`endif
    endfunction

    always_comb begin
        bus.data_in_ready = 1'b1;
        if (state == HOLD) begin
            bus.data_in_ready = bus.sum_ready;
        end
    end

    assign in_hs         = bus.data_in_valid & bus.data_in_ready;
    assign out_hs        = sum_valid_q & bus.sum_ready;
    assign bus.sum       = sum_q;
    assign bus.sum_valid = sum_valid_q;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state       <= WAIT_A;
            a_q         <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            case (state)
                WAIT_A: begin
                    if (in_hs) begin
                        a_q   <= bus.data_in;
                        state <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (in_hs) begin
                        sum_q       <= ext(a_q) + ext(bus.data_in);
                        sum_valid_q <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    // in_hs implies out_hs here: ready is the consumer's ready.
                    if (out_hs) begin
                        sum_valid_q <= 1'b0;
                        if (in_hs) begin
                            a_q   <= bus.data_in;
                            state <= WAIT_B;
                        end else begin
                            state <= WAIT_A;
                        end
                    end
                end
                default: begin
                    state       <= WAIT_A;
                    sum_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pair_adder.sv
// Directed, table-driven bench for pair_adder (WIDTH=8), honouring PAIR_ADDER_SIGNED_EN.
module tb_pair_adder;

    logic clk = 1'b0;
    logic arst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   hs_cnt = 0;
    int   hs_cyc[16];

    always #5 clk = ~clk;

    pair_adder_if #(.WIDTH(8)) bus ();

    pair_adder #(.WIDTH(8)) dut (
        .clk_i  (clk),
        .arst_ni(arst_n),
        .bus    (bus)
    );

    always @(posedge clk) begin
        cyc++;
        if (bus.sum_valid && bus.sum_ready) begin
            if (hs_cnt < 16) hs_cyc[hs_cnt] = cyc;
            hs_cnt++;
        end
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] exp_u;
        logic [8:0] exp_s;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting posedge, valid still high.
    task automatic push(input logic [7:0] d);
        int n;
        n = 0;
        bus.data_in       = d;
        bus.data_in_valid = 1'b1;
        #1;
        while (!bus.data_in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.data_in_ready) check("push_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_in();
        bus.data_in_valid = 1'b0;
        bus.data_in       = 8'hA5;
    endtask

    initial begin
        logic [8:0] exp;
        int base;

        vecs[0] = '{8'hFF, 8'h01, 9'h100, 9'h000};
        vecs[1] = '{8'h7F, 8'h01, 9'h080, 9'h080};
        vecs[2] = '{8'h80, 8'h80, 9'h100, 9'h100};
        vecs[3] = '{8'h00, 8'h00, 9'h000, 9'h000};
        vecs[4] = '{8'hFF, 8'hFF, 9'h1FE, 9'h1FE};
        vecs[5] = '{8'h12, 8'h34, 9'h046, 9'h046};
        vecs[6] = '{8'h80, 8'h7F, 9'h0FF, 9'h1FF};

        arst_n            = 1'b0;
        bus.data_in       = 8'h00;
        bus.data_in_valid = 1'b0;
        bus.sum_ready     = 1'b0;
        @(negedge clk);
        check("rst_sum", 32'(bus.sum), 32'h0);
        check("rst_valid", 32'(bus.sum_valid), 32'h0);
        @(negedge clk);
        arst_n = 1'b1;
        #1;
        check("rst_ready", 32'(bus.data_in_ready), 32'h1);
        @(negedge clk);

        // Table: pair, stall one cycle, consume.
        for (int i = 0; i < 7; i++) begin
`ifdef PAIR_ADDER_SIGNED_EN
            exp = vecs[i].exp_s;
`else
            exp = vecs[i].exp_u;
`endif
            bus.sum_ready = 1'b0;
            push(vecs[i].a);
            idle_in();
            check("vec_a_no_valid", 32'(bus.sum_valid), 32'h0);
            @(negedge clk);
            push(vecs[i].b);
            idle_in();
            check("vec_valid", 32'(bus.sum_valid), 32'h1);
            check("vec_sum", 32'(bus.sum), 32'(exp));
            @(negedge clk);
            check("vec_sum_hold", 32'(bus.sum), 32'(exp));
            bus.sum_ready = 1'b1;
            @(negedge clk);
            check("vec_consumed", 32'(bus.sum_valid), 32'h0);
            bus.sum_ready = 1'b0;
        end

        // Backpressure with input valid held high.
        base = hs_cnt;
        push(8'h10);
        push(8'h20);
        bus.data_in = 8'h99;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_ready", 32'(bus.data_in_ready), 32'h0);
            check("bp_sum", 32'(bus.sum), 32'h030);
            check("bp_valid", 32'(bus.sum_valid), 32'h1);
            @(negedge clk);
        end
        bus.sum_ready = 1'b1;
        #1;
        check("bp_rel_ready", 32'(bus.data_in_ready), 32'h1);
        @(negedge clk);
        check("bp_rel_consumed", 32'(bus.sum_valid), 32'h0);
        check("bp_rel_hs", 32'(hs_cnt - base), 32'h1);
        push(8'h01);
        idle_in();
        check("bp_next_sum", 32'(bus.sum), 32'h09A);
        check("bp_next_valid", 32'(bus.sum_valid), 32'h1);
        @(negedge clk);
        check("bp_next_consumed", 32'(bus.sum_valid), 32'h0);

        // Back-to-back pairs at full rate.
        base = hs_cnt;
        for (int p = 0; p < 4; p++) begin
            push(8'(2 * p + 1));
            check("b2b_a_valid", 32'(bus.sum_valid), 32'h0);
            push(8'(2 * p + 2));
            check("b2b_valid", 32'(bus.sum_valid), 32'h1);
            check("b2b_sum", 32'(bus.sum), 32'(4 * p + 3));
        end
        idle_in();
        @(negedge clk);
        check("b2b_count", 32'(hs_cnt - base), 32'd4);
        for (int p = 1; p < 4; p++) begin
            check("b2b_period", 32'(hs_cyc[base + p] - hs_cyc[base + p - 1]), 32'd2);
        end

        // Reset mid-pair discards the pending A.
        push(8'h55);
        idle_in();
        #2;
        arst_n = 1'b0;
        #1;
        check("rmid_sum", 32'(bus.sum), 32'h0);
        check("rmid_valid", 32'(bus.sum_valid), 32'h0);
        @(negedge clk);
        arst_n = 1'b1;
        push(8'h01);
        push(8'h02);
        idle_in();
        check("rmid_sum_after", 32'(bus.sum), 32'h003);
        @(negedge clk);

        // Reset while holding a result.
        bus.sum_ready = 1'b0;
        push(8'h0A);
        push(8'h0B);
        idle_in();
        check("rhold_valid_pre", 32'(bus.sum_valid), 32'h1);
        #2;
        arst_n = 1'b0;
        #1;
        check("rhold_valid_async", 32'(bus.sum_valid), 32'h0);
        check("rhold_sum_async", 32'(bus.sum), 32'h0);
        @(negedge clk);
        arst_n = 1'b1;
        #1;
        check("rhold_ready", 32'(bus.data_in_ready), 32'h1);
        @(negedge clk);
        push(8'h03);
        check("rhold_a_valid", 32'(bus.sum_valid), 32'h0);
        push(8'h04);
        idle_in();
        check("rhold_sum_after", 32'(bus.sum), 32'h007);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
